// File: rtl/regfile_pkg.sv
// Shared constants for the scoreboarded register file.
// These are the default geometry values and the hard-wired zero register.
package regfile_pkg;

  localparam int WORD      = 32;
  localparam int DEF_DEPTH = 32;
  localparam int DEF_NRD   = 3;
  localparam int DEF_NWR   = 2;
  localparam int ZERO_REG  = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-bit scoreboard: tracks registers that have an outstanding producer.
// It decides whether a reservation is accepted and whether each read operand is usable.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int NRD    = DEF_NRD,
  parameter int NWR    = DEF_NWR,
  parameter int BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD-1:0]        rd_ready,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic                  rsv_en,
  input  logic [ADDR_W-1:0]     rsv_addr,
  output logic                  rsv_ok,
  input  logic                  flush,
  output logic [DEPTH-1:0]      busy_vec
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0] busy_reg;
  logic [DEPTH-1:0] busy_next;
  logic [DEPTH-1:0] wr_hit;
  logic             rsv_set;

  // One-hot-per-register view of this cycle's committing writes.
  always_comb begin
    wr_hit = '0;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] != ZERO_ADDR)) begin
        wr_hit[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b1;
      end
    end
  end

  assign rsv_ok = !flush && ((rsv_addr == ZERO_ADDR) || !busy_reg[rsv_addr] || wr_hit[rsv_addr]);
  assign rsv_set = rsv_en && rsv_ok && (rsv_addr != ZERO_ADDR);

  // Reserve beats a same-edge writeback clear; flush beats everything.
  always_comb begin
    busy_next = busy_reg & ~wr_hit;
    if (rsv_set) begin
      busy_next[rsv_addr] = 1'b1;
    end
    if (flush) begin
      busy_next = '0;
    end
    busy_next[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign busy_vec = busy_reg;

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd_ready
    logic [ADDR_W-1:0] addr;
    assign addr = rd_addr[gi*ADDR_W +: ADDR_W];
    assign rd_ready[gi] = (addr == ZERO_ADDR) || !busy_reg[addr] ||
                          ((BYPASS != 0) && wr_hit[addr]);
  end

endmodule

// File: rtl/scoreboard_regfile.sv
// Multi-ported register file with write-to-read bypass and a WAW/RAW scoreboard.
// The array is flop-based so that reset clears it asynchronously and reads are combinational.
module scoreboard_regfile
  import regfile_pkg::*;
#(
  parameter int WIDTH  = WORD,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int NRD    = DEF_NRD,
  parameter int NWR    = DEF_NWR,
  parameter int BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*WIDTH-1:0]  rd_data,
  output logic [NRD-1:0]        rd_ready,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic [NWR*WIDTH-1:0]  wr_data,
  input  logic                  rsv_en,
  input  logic [ADDR_W-1:0]     rsv_addr,
  output logic                  rsv_ok,
  input  logic                  flush,
  output logic [DEPTH-1:0]      busy_vec
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [WIDTH-1:0] mem_reg  [DEPTH];
  logic [WIDTH-1:0] mem_next [DEPTH];

  // Ascending port order makes the highest-index port win a collision.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      mem_next[k] = mem_reg[k];
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(k)) && (k != ZERO_REG)) begin
          mem_next[k] = wr_data[j*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_reg[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_reg[k] <= mem_next[k];
      end
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd_port
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  rd_word;

    assign addr = rd_addr[gi*ADDR_W +: ADDR_W];

    // Bypass is suppressed in reset so the port reads the cleared array.
    always_comb begin
      rd_word = mem_reg[addr];
      if ((BYPASS != 0) && rst && (addr != ZERO_ADDR)) begin
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == addr)) begin
            rd_word = wr_data[j*WIDTH +: WIDTH];
          end
        end
      end
    end

    assign rd_data[gi*WIDTH +: WIDTH] = rd_word;
  end

  regfile_scoreboard #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .NRD    (NRD),
    .NWR    (NWR),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_ready (rd_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rsv_ok   (rsv_ok),
    .flush    (flush),
    .busy_vec (busy_vec)
  );

endmodule

// File: doc/scoreboard_regfile.md
SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

Interface
REQ-001 Parameter WIDTH, default `WORD (32), data word width in bits.
REQ-002 Parameter DEPTH, default 32, register count; SHALL be a power of two >= 2.
REQ-003 Parameter ADDR_W, default $clog2(DEPTH), register address width.
REQ-004 Parameter NRD, default 3, number of read ports (1..4).
REQ-005 Parameter NWR, default 2, number of write ports (1..3).
REQ-006 Parameter BYPASS, default 1: 1 forwards same-cycle write data to reads; 0 means no forwarding.
REQ-007 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-008 clk  in  1  rising-edge clock.
REQ-009 rst  in  1  asynchronous, active-low reset.
REQ-010 rd_addr  in  NRD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
REQ-011 rd_data  out  NRD*WIDTH  read data, packed the same way.
REQ-012 rd_ready  out  NRD  per-port operand valid: not pending, or bypassed.
REQ-013 wr_en  in  NWR  per-port write strobe (writeback).
REQ-014 wr_addr  in  NWR*ADDR_W  write addresses.
REQ-015 wr_data  in  NWR*WIDTH  write data.
REQ-016 rsv_en  in  1  reserve request: mark the destination register pending (issue).
REQ-017 rsv_addr  in  ADDR_W  register to reserve.
REQ-018 rsv_ok  out  1  reservation is accepted this cycle if rsv_en is high.
REQ-019 flush  in  1  clear all pending bits (pipeline squash).
REQ-020 busy_vec  out  DEPTH  current pending bits; bit 0 is always 0.

Function
REQ-021 Register 0 SHALL read 0, ignore all writes, and never become busy.
REQ-022 Reads SHALL be combinational from the array; no read latency.
REQ-023 Writes SHALL commit on the rising clk edge with wr_en high and a nonzero address.
- Same-address collision across write ports: the highest-index port wins.
REQ-024 When BYPASS=1 and wr_en[j] matches rd_addr[i] (nonzero), rd_data[i] SHALL be wr_data[j], using the highest-index matching j.
- When BYPASS=0, reads SHALL return the pre-edge array value.
REQ-025 Busy clear: a committed write to address a SHALL clear busy[a] at the same edge.
REQ-026 rsv_ok SHALL be 1 when any of these holds:
- rsv_addr==0;
- busy[rsv_addr]==0;
- a write to rsv_addr occurs this cycle.
- Otherwise rsv_ok SHALL be 0 (WAW stall).
- rsv_ok SHALL be 0 whenever flush is high.
REQ-027 Busy set: rsv_en && rsv_ok && rsv_addr!=0 SHALL set busy[rsv_addr] at the edge.
- A reserve takes priority over a same-cycle clear of the same address, so the bit ends at 1 (new producer).
REQ-028 rd_ready[i] SHALL be 1 when rd_addr[i]==0 or busy[rd_addr[i]]==0.
- Also 1 when BYPASS=1 and a same-cycle write hits rd_addr[i].
- Otherwise 0.
REQ-029 flush SHALL clear every busy bit at the edge and override same-cycle reserves; array contents and same-cycle writes SHALL be unaffected.
REQ-030 A rsv_en with rsv_ok=0 SHALL have no effect; the requester holds and retries.

Reset
REQ-031 With rst low, all registers SHALL read 0 and busy_vec SHALL be 0, asynchronously, regardless of clk.
REQ-032 At reset, outputs SHALL be: rd_data 0, rd_ready all 1, and rsv_ok 1 (if flush is low).
REQ-033 A reset asserted mid-operation SHALL discard all pending reservations and in-flight writes.
REQ-034 Writes and reserves SHALL resume on the first rising edge after rst deasserts.

Structure
REQ-035 Package regfile_pkg SHALL hold the default WIDTH, DEPTH, NRD and NWR constants and the zero-register address constant.
REQ-036 Sub-module regfile_scoreboard SHALL own the busy_vec state, rsv_ok and rd_ready logic.
- The top level holds the data array and the write/bypass muxing.

Verification
REQ-037 Reset then read all addresses -> rd_data=0, rd_ready=all 1, busy_vec=0.
REQ-038 Write ports 0 and 1 both target reg 5 (0xAAAA, 0x5555) -> next cycle reg 5 reads 0x5555.
- With BYPASS=1 the same cycle also reads 0x5555.
REQ-039 Reserve reg 7:
- then rd_addr=7 -> rd_ready=0;
- a second reserve of 7 -> rsv_ok=0;
- write 0x1234 to 7 -> rd_ready=1 in the write cycle (BYPASS=1) and busy[7]=0 after the edge.
REQ-040 Reserve reg 9 while a write to 9 occurs in the same cycle -> rsv_ok=1, busy[9]=1 after the edge, reg 9 holds the written value.
REQ-041 Reserve regs 3, 4, 6, then assert flush together with rsv_en on reg 8 -> busy_vec=0 and rsv_ok=0; the array is unchanged.
REQ-042 Write reg 0 = 0xFFFF and reserve reg 0 -> reads 0, busy_vec[0]=0.
- Then assert rst mid-stream with reg 2 busy -> busy_vec=0 and all registers read 0 immediately.
